// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - run-state encoding and opcode constants for cpu_run_ctrl
package cpu_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_t;

    localparam logic [31:0] HALT_INSN_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - core-side retire/fetch bus and execution enable
interface cpu_run_ctrl_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic [XLEN-1:0] pc_addr;
    logic [ILEN-1:0] instruction;
    logic            insn_valid;
    logic            branch_taken;
    logic            core_en;

    modport master (
        output pc_addr, instruction, insn_valid, branch_taken,
        input  core_en
    );

    modport slave (
        input  pc_addr, instruction, insn_valid, branch_taken,
        output core_en
    );
endinterface

// File: rtl/run_trace_buf.sv
// rtl/run_trace_buf.sv - circular buffer of taken-branch PCs, index 0 reads the newest entry
module run_trace_buf #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [XLEN-1:0]  push_pc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_pc,
    output logic [IDX_W:0]   count
);
    logic [XLEN-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_pc;
            wr_ptr      <= wr_ptr + IDX_W'(1);
            if (count != (IDX_W+1)'(DEPTH)) count <= count + (IDX_W+1)'(1);
        end
    end

    // Power-of-two depth lets the pointer arithmetic wrap for free.
    assign rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_pc  = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - start/halt/timeout run control with cycle, retire and branch counters
// Optional branch-PC trace is built when CPU_RUN_CTRL_TRACE_EN is defined.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int CNT_W = 32,
    parameter logic [ILEN-1:0] HALT_INSN = ILEN'(HALT_INSN_DEF)
`ifdef CPU_RUN_CTRL_TRACE_EN
    ,
    parameter int TRACE_DEPTH = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    cpu_run_ctrl_if.slave       bus,
    input  logic                start,
    input  logic [CNT_W-1:0]    max_cycles,
    output logic [1:0]          run_state,
    output logic                done,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    insn_cnt,
    output logic [CNT_W-1:0]    branch_cnt,
    output logic [XLEN-1:0]     halt_pc
`ifdef CPU_RUN_CTRL_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
`endif
);
    run_state_t       state_q, state_d;
    logic             clear, count_en, halt_hit, retire;
    logic [CNT_W-1:0] cycle_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cycle_inc = sat_inc(cycle_cnt);

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        count_en = 1'b0;
        halt_hit = 1'b0;
        retire   = 1'b0;
        case (state_q)
            ST_RUN: begin
                count_en = 1'b1;
                halt_hit = bus.insn_valid && (bus.instruction == HALT_INSN);
                retire   = bus.insn_valid && !halt_hit;
                // HALT takes priority over a timeout landing on the same cycle.
                if (halt_hit)
                    state_d = ST_HALTED;
                else if ((max_cycles != '0) && (cycle_inc == max_cycles))
                    state_d = ST_TIMEOUT;
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus.core_en <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus.core_en <= (state_d == ST_RUN);
            done        <= (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            insn_cnt   <= '0;
            branch_cnt <= '0;
            halt_pc    <= '0;
        end else if (clear) begin
            cycle_cnt  <= '0;
            insn_cnt   <= '0;
            branch_cnt <= '0;
            halt_pc    <= '0;
        end else if (count_en) begin
            cycle_cnt <= cycle_inc;
            if (halt_hit) halt_pc <= bus.pc_addr;
            if (retire) begin
                insn_cnt <= sat_inc(insn_cnt);
                if (bus.branch_taken) branch_cnt <= sat_inc(branch_cnt);
            end
        end
    end

    assign run_state = state_q;

`ifdef CPU_RUN_CTRL_TRACE_EN
    run_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .XLEN  (XLEN)
    ) u_trace (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (retire && bus.branch_taken),
        .push_pc (bus.pc_addr),
        .rd_idx  (trace_idx),
        .rd_pc   (trace_pc),
        .count   (trace_count)
    );
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - table-driven run scenarios with scoreboard plus reset/restart sequences
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] max_cycles;
    logic [1:0]  run_state;
    logic        done;
    logic [31:0] cycle_cnt, insn_cnt, branch_cnt;
    logic [63:0] halt_pc;
`ifdef CPU_RUN_CTRL_TRACE_EN
    logic [2:0]  trace_idx;
    logic [63:0] trace_pc;
    logic [3:0]  trace_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.XLEN(64), .ILEN(32)) bus ();

    cpu_run_ctrl #(
        .XLEN(64), .ILEN(32), .CNT_W(32), .HALT_INSN(32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .start      (start),
        .max_cycles (max_cycles),
        .run_state  (run_state),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .insn_cnt   (insn_cnt),
        .branch_cnt (branch_cnt),
        .halt_pc    (halt_pc)
`ifdef CPU_RUN_CTRL_TRACE_EN
        ,
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc),
        .trace_count (trace_count)
`endif
    );

    typedef struct {
        logic [31:0] max_c;
        int          n_insn;
        bit          gap;
        bit          br;
        bit          halt;
        logic [63:0] base;
        logic [1:0]  e_state;
        logic [31:0] e_cyc;
        logic [31:0] e_insn;
        logic [31:0] e_br;
        logic [63:0] e_hpc;
    } vec_t;

    vec_t vecs[7];
    vec_t sb[$];
    vec_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit b, input logic [31:0] insn, input logic [63:0] pc);
        bus.insn_valid   = v;
        bus.branch_taken = b;
        bus.instruction  = insn;
        bus.pc_addr      = pc;
    endtask

    task automatic start_run(input logic [31:0] mc);
        max_cycles = mc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", 64'(run_state), 64'(ST_RUN));
        chk("start_core_en", 64'(bus.core_en), 64'd1);
        chk("start_cycle_clr", 64'(cycle_cnt), 64'd0);
        chk("start_insn_clr", 64'(insn_cnt), 64'd0);
        chk("start_hpc_clr", halt_pc, 64'd0);
    endtask

    initial begin
        //        max  n    gap br halt base     state       cyc insn br  hpc
        vecs[0] = '{32'd0,  7,    0, 0, 1, 64'h000, ST_HALTED,  8,  7,  0, 64'h01C};
        vecs[1] = '{32'd50, 1000, 0, 0, 0, 64'h000, ST_TIMEOUT, 50, 50, 0, 64'h000};
        vecs[2] = '{32'd4,  3,    0, 0, 1, 64'h000, ST_HALTED,  4,  3,  0, 64'h00C};
        vecs[3] = '{32'd0,  10,   0, 1, 1, 64'h100, ST_HALTED,  11, 10, 10, 64'h128};
        vecs[4] = '{32'd0,  8,    1, 1, 1, 64'h200, ST_HALTED,  9,  4,  4, 64'h220};
        vecs[5] = '{32'd7,  1000, 1, 1, 0, 64'h300, ST_TIMEOUT, 7,  4,  4, 64'h000};
        vecs[6] = '{32'd1,  5,    0, 1, 1, 64'h400, ST_TIMEOUT, 1,  1,  1, 64'h000};

        rst = 1'b1;
        start = 1'b0;
        max_cycles = '0;
        drive(1'b0, 1'b0, NOP_INSN, 64'h0);
`ifdef CPU_RUN_CTRL_TRACE_EN
        trace_idx = '0;
`endif
        tick();
        tick();
        chk("rst_state", 64'(run_state), 64'(ST_IDLE));
        chk("rst_core_en", 64'(bus.core_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cycle", 64'(cycle_cnt), 64'd0);
        chk("rst_insn", 64'(insn_cnt), 64'd0);
        chk("rst_branch", 64'(branch_cnt), 64'd0);
        chk("rst_hpc", halt_pc, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_hold", 64'(run_state), 64'(ST_IDLE));

        for (int v = 0; v < 7; v++) begin
            start_run(vecs[v].max_c);
            sb.push_back(vecs[v]);
            for (int c = 0; c < 300; c++) begin
                if (vecs[v].halt && c == vecs[v].n_insn)
                    drive(1'b1, vecs[v].br, HALT_INSN_DEF, vecs[v].base + 64'(4 * c));
                else
                    drive(vecs[v].gap ? (c % 2 == 0) : 1'b1, vecs[v].br, NOP_INSN,
                          vecs[v].base + 64'(4 * c));
                tick();
                if (run_state != ST_RUN) break;
            end
            drive(1'b0, 1'b0, NOP_INSN, 64'h0);
            e = sb.pop_front();
            chk($sformatf("v%0d_state", v), 64'(run_state), 64'(e.e_state));
            chk($sformatf("v%0d_cycle", v), 64'(cycle_cnt), 64'(e.e_cyc));
            chk($sformatf("v%0d_insn", v), 64'(insn_cnt), 64'(e.e_insn));
            chk($sformatf("v%0d_branch", v), 64'(branch_cnt), 64'(e.e_br));
            chk($sformatf("v%0d_hpc", v), halt_pc, e.e_hpc);
            chk($sformatf("v%0d_done", v), 64'(done), 64'd1);
            chk($sformatf("v%0d_core_en", v), 64'(bus.core_en), 64'd0);
`ifdef CPU_RUN_CTRL_TRACE_EN
            if (v == 3) begin
                chk("trace_count", 64'(trace_count), 64'd8);
                trace_idx = 3'd0;
                #1 chk("trace_idx0", trace_pc, 64'h124);
                trace_idx = 3'd7;
                #1 chk("trace_idx7", trace_pc, 64'h108);
            end
            if (v == 6) begin
                chk("trace_count_one", 64'(trace_count), 64'd1);
                trace_idx = 3'd0;
                #1 chk("trace_one_idx0", trace_pc, 64'h400);
                trace_idx = 3'd1;
                #1 chk("trace_oob", trace_pc, 64'h0);
            end
`endif
        end

        // Retire inputs are ignored once the run has ended.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, NOP_INSN, 64'h500);
            tick();
        end
        drive(1'b0, 1'b0, NOP_INSN, 64'h0);
        chk("post_state", 64'(run_state), 64'(ST_TIMEOUT));
        chk("post_cycle", 64'(cycle_cnt), 64'd1);
        chk("post_insn", 64'(insn_cnt), 64'd1);
        chk("post_branch", 64'(branch_cnt), 64'd1);

        // Start in RUN must not restart the counters.
        start_run(32'd0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, NOP_INSN, 64'(4 * c));
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_ignored_cycle", 64'(cycle_cnt), 64'd4);
        chk("run_start_ignored_insn", 64'(insn_cnt), 64'd4);
        tick();
        chk("pre_rst_cycle", 64'(cycle_cnt), 64'd5);

        // Asynchronous reset mid-run, checked before any further clock edge.
        #1 rst = 1'b1;
        #1;
        chk("async_rst_state", 64'(run_state), 64'(ST_IDLE));
        chk("async_rst_cycle", 64'(cycle_cnt), 64'd0);
        chk("async_rst_insn", 64'(insn_cnt), 64'd0);
        chk("async_rst_core_en", 64'(bus.core_en), 64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, NOP_INSN, 64'h0);
        tick();

        // Halt, then restart from HALTED.
        start_run(32'd0);
        drive(1'b1, 1'b0, NOP_INSN, 64'h40);
        tick();
        drive(1'b1, 1'b0, HALT_INSN_DEF, 64'h44);
        tick();
        drive(1'b0, 1'b0, NOP_INSN, 64'h0);
        chk("h2_state", 64'(run_state), 64'(ST_HALTED));
        chk("h2_hpc", halt_pc, 64'h44);
        chk("h2_cycle", 64'(cycle_cnt), 64'd2);
        start_run(32'd0);
        chk("restart_insn_clr", 64'(insn_cnt), 64'd0);
        chk("restart_done", 64'(done), 64'd0);
        chk("queue_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
